// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: grants one producer at a time a burst of up to MAX_BURST
// words into a shared FIFO write port, with a per-word ack back to the owning producer.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned bitsize   = 44,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDW       = 2
) (
  input  logic                    clk,
  input  logic                    rstp,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*bitsize-1:0] req_data,
  output logic [NREQ-1:0]         ack,
  input  logic                    fifo_fullp,
  output logic                    fifo_writep,
  output logic [bitsize-1:0]      fifo_data,
  output logic                    grant_valid,
  output logic [IDW-1:0]          grant_id
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {StIdle, StOwn} state_e;

  state_e         state_q;
  logic [IDW-1:0] owner_q;
  logic [IDW-1:0] last_owner_q;
  logic [CW-1:0]  burst_cnt_q;

  logic [bitsize-1:0] slices [NREQ];
  logic [IDW-1:0]     winner;
  logic               found;
  logic               own;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      slices[i] = req_data[i*bitsize +: bitsize];
    end
  end

  // Scan starts one past the previous owner so every requester is served in turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (int'(last_owner_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign own = (state_q == StOwn);

  always_comb begin
    fifo_writep = !rstp && own && req[owner_q] && !fifo_fullp;
    ack         = '0;
    if (fifo_writep) begin
      ack[owner_q] = 1'b1;
    end
    fifo_data   = (own && !rstp) ? slices[owner_q] : '0;
    grant_valid = own && !rstp;
    grant_id    = owner_q;
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IDW'(NREQ - 1);
      burst_cnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            owner_q     <= winner;
            burst_cnt_q <= '0;
            state_q     <= StOwn;
          end
        end
        StOwn: begin
          if (!req[owner_q]) begin
            state_q      <= StIdle;
            last_owner_q <= owner_q;
          end else if (fifo_writep) begin
            burst_cnt_q <= burst_cnt_q + CW'(1);
            if (burst_cnt_q == CW'(MAX_BURST - 1)) begin
              state_q      <= StIdle;
              last_owner_q <= owner_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: producers obey the hold-until-ack protocol and a
// grant-level reference model predicts every output each cycle.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned BITSIZE   = 44;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned IDW       = 2;

  logic                    clk = 1'b0;
  logic                    rstp;
  logic [NREQ-1:0]         req;
  logic [NREQ*BITSIZE-1:0] req_data;
  logic [NREQ-1:0]         ack;
  logic                    fifo_fullp;
  logic                    fifo_writep;
  logic [BITSIZE-1:0]      fifo_data;
  logic                    grant_valid;
  logic [IDW-1:0]          grant_id;

  logic [BITSIZE-1:0] word [NREQ];
  logic [NREQ-1:0]    ack_seen;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;  // 0: random traffic, 1: saturation

  // Reference model: owner (-1 = nobody), words written in this grant, previous owner.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_prev  = NREQ - 1;
  int m_gid   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*BITSIZE +: BITSIZE] = word[i];
    end
  end

  fifo_wr_arbiter #(
    .NREQ     (NREQ),
    .bitsize  (BITSIZE),
    .MAX_BURST(MAX_BURST),
    .IDW      (IDW)
  ) dut (
    .clk        (clk),
    .rstp       (rstp),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_fullp (fifo_fullp),
    .fifo_writep(fifo_writep),
    .fifo_data  (fifo_data),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BITSIZE-1:0] rand_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[BITSIZE-1:0];
  endfunction

  // Entered at a falling edge with inputs settled; checks, then advances one clock.
  task automatic cycle();
    logic               e_wr;
    logic [NREQ-1:0]    e_ack;
    logic [BITSIZE-1:0] e_data;
    logic               e_gv;
    int n_owner, n_cnt, n_prev, n_gid;
    #1;
    e_wr   = 1'b0;
    e_ack  = '0;
    e_data = '0;
    e_gv   = 1'b0;
    if (m_owner >= 0 && !rstp) begin
      e_gv   = 1'b1;
      e_data = word[m_owner];
      e_wr   = req[m_owner] && !fifo_fullp;
      if (e_wr) e_ack[m_owner] = 1'b1;
    end
    check("writep", fifo_writep, e_wr);
    check("ack", ack, e_ack);
    check("grant_valid", grant_valid, e_gv);
    check("fifo_data", fifo_data, e_data);
    if (!rstp) check("grant_id", grant_id, m_gid);

    n_owner = m_owner;
    n_cnt   = m_cnt;
    n_prev  = m_prev;
    n_gid   = m_gid;
    if (rstp) begin
      n_owner = -1;
      n_cnt   = 0;
      n_prev  = NREQ - 1;
      n_gid   = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_prev + k) % NREQ;
        if (n_owner < 0 && req[c]) begin
          n_owner = c;
          n_gid   = c;
          n_cnt   = 0;
        end
      end
    end else if (!req[m_owner]) begin
      n_prev  = m_owner;
      n_owner = -1;
    end else if (e_wr) begin
      n_cnt = m_cnt + 1;
      if (n_cnt == MAX_BURST) begin
        n_prev  = m_owner;
        n_owner = -1;
      end
    end
    ack_seen = ack;

    @(posedge clk);
    #1;
    m_owner = n_owner;
    m_cnt   = n_cnt;
    m_prev  = n_prev;
    m_gid   = n_gid;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && ack_seen[i]) begin
        if (mode != 0 || $urandom_range(0, 3) != 0) word[i] = rand_word();
        else req[i] = 1'b0;
      end else if (!req[i] && (mode != 0 || $urandom_range(0, 2) == 0)) begin
        req[i]  = 1'b1;
        word[i] = rand_word();
      end
    end
    fifo_fullp = (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int writes;
    logic prev_wr;
    int order[$];

    rstp       = 1'b1;
    req        = '0;
    fifo_fullp = 1'b0;
    for (int i = 0; i < NREQ; i++) word[i] = '0;
    @(negedge clk);
    cycle();
    cycle();
    rstp = 1'b0;

    // Saturation: every producer always requesting, FIFO never full.
    mode = 1;
    rstp = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i]) begin
        req[i]  = 1'b1;
        word[i] = rand_word();
      end
    end
    cycle();
    rstp    = 1'b0;
    writes  = 0;
    prev_wr = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c < 20 && fifo_writep) writes++;
      if (fifo_writep && !prev_wr) order.push_back(int'(grant_id));
      prev_wr = fifo_writep;
      cycle();
    end
    check("sat_writes_in_20", writes, 16);
    check("sat_burst_count", order.size(), 5);
    for (int k = 0; k < order.size() && k < 5; k++) begin
      check("sat_grant_order", order[k], k % NREQ);
    end

    // Reset in the middle of a burst: outputs gated, then producer 0 wins first.
    check("pre_rst_writing", fifo_writep, 1'b1);
    rstp = 1'b1;
    cycle();
    rstp = 1'b0;
    cycle();
    cycle();
    check("rst_first_gid", grant_id, 0);
    check("rst_first_gv", grant_valid, 1'b1);

    // Random traffic with random FIFO-full stalls and occasional resets.
    mode = 0;
    repeat (3000) begin
      rstp = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rstp = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
